// File: rtl/local_node_if_pkg.sv
// Shared definitions for the mesh node local-port interface.
// Holds the default flit field widths, the data-flit header code, the
// router direction indices and the FSM state encodings used by the
// injection and ejection paths.
package local_node_if_pkg;

  localparam int ADDR_SZ = 4;
  localparam int PL_SZ   = 8;
  localparam int HDR_SZ  = 2;

  localparam logic [1:0] HDR_DATA = 2'b01;

  // Router port indices; this interface attaches to LOCAL.
  localparam int DIR_NORTH = 0;
  localparam int DIR_EAST  = 1;
  localparam int DIR_SOUTH = 2;
  localparam int DIR_WEST  = 3;
  localparam int DIR_LOCAL = 4;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_HOLD  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/node_ser.sv
// Injection serialiser for the local node interface.
// A holding register accepts one flit from the core; the TX FSM moves it
// into a shift register and sends a start bit followed by FLIT_W data bits,
// LSB first. The holding register can be refilled while a frame shifts out.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   inject_req     core request to inject inject_flit
//   inject_flit    fully assembled flit {hdr, payload, addr}
//   inject_ack     registered one-cycle pulse: flit captured
//   tx_busy        router LOCAL rx busy, sampled only before a start bit
//   tx_data        registered serial line into the router
module node_ser #(
  parameter int FLIT_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inject_req,
  input  logic [FLIT_W-1:0] inject_flit,
  output logic              inject_ack,
  input  logic              tx_busy,
  output logic              tx_data
);
  import local_node_if_pkg::*;

  localparam int CNT_W = $clog2(FLIT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLIT_W - 1);

  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLIT_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [FLIT_W-1:0] shift_q, shift_d;
  logic              ack_q, ack_d;
  logic              tx_data_q, tx_data_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    ack_d       = 1'b0;
    tx_data_d   = 1'b0;

    // Capture uses the registered empty flag, so a slot freed this cycle
    // becomes available to the core on the next one.
    if (inject_req && !hold_full_q) begin
      ack_d       = 1'b1;
      hold_d      = inject_flit;
      hold_full_d = 1'b1;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (hold_full_q && !tx_busy) begin
          tx_data_d   = 1'b1;
          shift_d     = hold_q;
          hold_d      = '0;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          tx_state_d  = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        tx_data_d = shift_q[0];
        shift_d   = shift_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---- register stage: TX state and outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      ack_q       <= 1'b0;
      tx_data_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign inject_ack = ack_q;
  assign tx_data    = tx_data_q;

endmodule

// File: rtl/local_node_if.sv
// Local-port network interface for one mesh node.
// Injection: builds {HDR_DATA, payload, dest} flits and serialises them
// onto the router LOCAL rx link through node_ser.
// Ejection: deserialises frames from the router LOCAL tx link, holds the
// flit for the core until rcv_read, and keeps saturating delivery and
// error counters (address != NODE_ID or header != HDR_DATA).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inject_req/dest/payload/ack     core injection handshake
//   tx_data, tx_busy                serial link into the router
//   rx_data, rx_busy                serial link from the router
//   rcv_valid/payload/dest/read     held received flit and consume strobe
//   rcv_count, err_count            saturating 16-bit counters
module local_node_if #(
  parameter int NODE_ID = 0,
  parameter int ADDR_SZ = local_node_if_pkg::ADDR_SZ,
  parameter int PL_SZ   = local_node_if_pkg::PL_SZ,
  parameter int HDR_SZ  = local_node_if_pkg::HDR_SZ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inject_req,
  input  logic [ADDR_SZ-1:0] inject_dest,
  input  logic [PL_SZ-1:0]   inject_payload,
  output logic               inject_ack,
  output logic               tx_data,
  input  logic               tx_busy,
  input  logic               rx_data,
  output logic               rx_busy,
  output logic               rcv_valid,
  output logic [PL_SZ-1:0]   rcv_payload,
  output logic [ADDR_SZ-1:0] rcv_dest,
  input  logic               rcv_read,
  output logic [15:0]        rcv_count,
  output logic [15:0]        err_count
);
  import local_node_if_pkg::*;

  localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int CNT_W  = $clog2(FLIT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLIT_W - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  node_ser #(
    .FLIT_W(FLIT_W)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .inject_req (inject_req),
    .inject_flit({HDR_SZ'(HDR_DATA), inject_payload, inject_dest}),
    .inject_ack (inject_ack),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data)
  );

  rx_state_e          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [FLIT_W-1:0]  rx_shift_q, rx_shift_d;
  logic               rx_busy_q, rx_busy_d;
  logic               rcv_valid_q, rcv_valid_d;
  logic [PL_SZ-1:0]   rcv_payload_q, rcv_payload_d;
  logic [ADDR_SZ-1:0] rcv_dest_q, rcv_dest_d;
  logic [15:0]        rcv_count_q, rcv_count_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [FLIT_W-1:0]  rx_flit;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_shift_d    = rx_shift_q;
    rcv_valid_d   = rcv_valid_q;
    rcv_payload_d = rcv_payload_q;
    rcv_dest_d    = rcv_dest_q;
    rcv_count_d   = rcv_count_q;
    err_count_d   = err_count_q;
    // LSB arrives first, so each new bit enters at the top.
    rx_flit       = {rx_data, rx_shift_q[FLIT_W-1:1]};

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_data) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        rx_shift_d = rx_flit;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_LAST) begin
          rx_state_d    = RX_HOLD;
          rcv_valid_d   = 1'b1;
          rcv_payload_d = rx_flit[ADDR_SZ +: PL_SZ];
          rcv_dest_d    = rx_flit[ADDR_SZ-1:0];
          rcv_count_d   = sat_inc16(rcv_count_q);
          // Misrouted or non-data flits are still delivered, only counted.
          if ((rx_flit[ADDR_SZ-1:0] != ADDR_SZ'(NODE_ID)) ||
              (rx_flit[FLIT_W-1 -: HDR_SZ] != HDR_SZ'(HDR_DATA))) begin
            err_count_d = sat_inc16(err_count_q);
          end
        end
      end
      RX_HOLD: begin
        if (rcv_read) begin
          rcv_valid_d = 1'b0;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    rx_busy_d = (rx_state_d != RX_IDLE);
  end

  // ---- register stage: RX state, held flit and counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_shift_q    <= '0;
      rx_busy_q     <= 1'b0;
      rcv_valid_q   <= 1'b0;
      rcv_payload_q <= '0;
      rcv_dest_q    <= '0;
      rcv_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_busy_q     <= rx_busy_d;
      rcv_valid_q   <= rcv_valid_d;
      rcv_payload_q <= rcv_payload_d;
      rcv_dest_q    <= rcv_dest_d;
      rcv_count_q   <= rcv_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign rx_busy     = rx_busy_q;
  assign rcv_valid   = rcv_valid_q;
  assign rcv_payload = rcv_payload_q;
  assign rcv_dest    = rcv_dest_q;
  assign rcv_count   = rcv_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_local_node_if.sv
module tb_local_node_if;

  localparam int FW = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        inject_req;
  logic [3:0]  inject_dest;
  logic [7:0]  inject_payload;
  logic        inject_ack;
  logic        tx_data;
  logic        tx_busy;
  logic        rx_data;
  logic        rx_busy;
  logic        rcv_valid;
  logic [7:0]  rcv_payload;
  logic [3:0]  rcv_dest;
  logic        rcv_read;
  logic [15:0] rcv_count;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  local_node_if #(
    .NODE_ID(5),
    .ADDR_SZ(4),
    .PL_SZ  (8),
    .HDR_SZ (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inject_req    (inject_req),
    .inject_dest   (inject_dest),
    .inject_payload(inject_payload),
    .inject_ack    (inject_ack),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .rx_data       (rx_data),
    .rx_busy       (rx_busy),
    .rcv_valid     (rcv_valid),
    .rcv_payload   (rcv_payload),
    .rcv_dest      (rcv_dest),
    .rcv_read      (rcv_read),
    .rcv_count     (rcv_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  dest;
    logic [7:0]  pl;
    logic [13:0] flit;
  } tx_vec_t;

  typedef struct {
    logic [1:0] hdr;
    logic [7:0] pl;
    logic [3:0] dest;
    logic       bad;
  } rx_vec_t;

  tx_vec_t txv[3];
  rx_vec_t rxv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Router side: start bit then FLIT bits LSB first, one per clock.
  task automatic rx_frame(input logic [13:0] f);
    rx_data = 1'b1;
    tick();
    chk("rx_busy_rise", rx_busy, 1);
    for (int i = 0; i < FW; i++) begin
      rx_data = f[i];
      tick();
      if (i == FW - 2) chk("rcv_valid_early", rcv_valid, 0);
    end
    rx_data = 1'b0;
  endtask

  task automatic tx_collect(output logic [13:0] got);
    for (int i = 0; i < FW; i++) begin
      tick();
      got[i] = tx_data;
    end
  endtask

  task automatic do_read();
    rcv_read = 1'b1;
    tick();
    rcv_read = 1'b0;
    chk("read_valid_fall", rcv_valid, 0);
    chk("read_busy_fall", rx_busy, 0);
  endtask

  initial begin
    logic [13:0] got;
    logic [13:0] f;
    int exp_rcv;
    int exp_err;
    int bad;

    txv[0] = '{4'd3, 8'hA5, 14'h1A53};
    txv[1] = '{4'hF, 8'h00, 14'h100F};
    txv[2] = '{4'd5, 8'h3C, 14'h13C5};

    rxv[0] = '{2'b01, 8'h3C, 4'd5, 1'b0};
    rxv[1] = '{2'b01, 8'hA5, 4'd7, 1'b1};
    rxv[2] = '{2'b10, 8'h5A, 4'd5, 1'b1};
    rxv[3] = '{2'b01, 8'hC3, 4'd5, 1'b0};

    reset = 1'b1;
    inject_req = 1'b0;
    inject_dest = '0;
    inject_payload = '0;
    tx_busy = 1'b0;
    rx_data = 1'b0;
    rcv_read = 1'b0;
    repeat (3) tick();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ack", inject_ack, 0);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_valid", rcv_valid, 0);
    chk("rst_payload", rcv_payload, 0);
    chk("rst_dest", rcv_dest, 0);
    chk("rst_rcv_count", rcv_count, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    tick();

    // Injection vectors
    for (int v = 0; v < 3; v++) begin
      inject_dest = txv[v].dest;
      inject_payload = txv[v].pl;
      inject_req = 1'b1;
      tick();
      chk("tx_ack", inject_ack, 1);
      inject_req = 1'b0;
      tick();
      chk("tx_ack_pulse", inject_ack, 0);
      chk("tx_start", tx_data, 1);
      tx_collect(got);
      chk("tx_frame", got, txv[v].flit);
      tick();
      chk("tx_line_idle", tx_data, 0);
    end

    // tx_busy stall with a second request waiting behind the first
    tx_busy = 1'b1;
    inject_dest = 4'd3;
    inject_payload = 8'hA5;
    inject_req = 1'b1;
    tick();
    chk("stall_ack_first", inject_ack, 1);
    inject_dest = 4'hF;
    inject_payload = 8'h00;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_data !== 1'b0 || inject_ack !== 1'b0) bad++;
    end
    chk("stall_no_start_no_ack", bad, 0);
    tx_busy = 1'b0;
    tick();
    chk("stall_start_after_busy", tx_data, 1);
    for (int i = 0; i < FW; i++) begin
      tick();
      got[i] = tx_data;
      if (i == 0) begin
        chk("stall_second_ack", inject_ack, 1);
        inject_req = 1'b0;
      end
    end
    chk("stall_frame_a", got, 14'h1A53);
    tick();
    chk("b2b_start", tx_data, 1);
    tx_collect(got);
    chk("b2b_frame_b", got, 14'h100F);
    tick();
    chk("b2b_line_idle", tx_data, 0);

    // Ejection vectors
    exp_rcv = 0;
    exp_err = 0;
    for (int v = 0; v < 4; v++) begin
      f = {rxv[v].hdr, rxv[v].pl, rxv[v].dest};
      rx_frame(f);
      exp_rcv++;
      if (rxv[v].bad) exp_err++;
      chk("rx_valid", rcv_valid, 1);
      chk("rx_busy_held", rx_busy, 1);
      chk("rx_payload", rcv_payload, rxv[v].pl);
      chk("rx_dest", rcv_dest, rxv[v].dest);
      chk("rx_rcv_count", rcv_count, exp_rcv);
      chk("rx_err_count", err_count, exp_err);
      do_read();
    end

    // read strobe with nothing held
    rcv_read = 1'b1;
    repeat (2) tick();
    rcv_read = 1'b0;
    chk("stray_read_valid", rcv_valid, 0);
    chk("stray_read_count", rcv_count, exp_rcv);

    // core stalls: router start bit during hold must be ignored
    rx_frame({2'b01, 8'h77, 4'd5});
    exp_rcv++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      rx_data = (i == 5);
      tick();
      if (rx_busy !== 1'b1 || rcv_valid !== 1'b1) bad++;
    end
    rx_data = 1'b0;
    chk("hold_busy_valid", bad, 0);
    chk("hold_payload", rcv_payload, 8'h77);
    chk("hold_count", rcv_count, exp_rcv);
    do_read();
    rx_frame({2'b01, 8'h81, 4'd5});
    exp_rcv++;
    chk("after_hold_payload", rcv_payload, 8'h81);
    chk("after_hold_count", rcv_count, exp_rcv);
    chk("after_hold_err", err_count, exp_err);
    do_read();

    // asynchronous reset in the middle of both frames
    f = {2'b01, 8'h3C, 4'd5};
    inject_dest = 4'd2;
    inject_payload = 8'h33;
    inject_req = 1'b1;
    rx_data = 1'b1;
    tick();
    chk("rst_mid_ack", inject_ack, 1);
    for (int i = 0; i < 8; i++) begin
      rx_data = f[i];
      if (i == 0) inject_req = 1'b0;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_rx_busy", rx_busy, 0);
    chk("mid_rst_valid", rcv_valid, 0);
    chk("mid_rst_rcv_count", rcv_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_payload", rcv_payload, 0);
    rx_data = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_data !== 1'b0 || rx_busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    rx_frame({2'b01, 8'hC3, 4'd5});
    chk("post_rst_valid", rcv_valid, 1);
    chk("post_rst_payload", rcv_payload, 8'hC3);
    chk("post_rst_dest", rcv_dest, 4'd5);
    chk("post_rst_rcv_count", rcv_count, 1);
    chk("post_rst_err_count", err_count, 0);
    do_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
